// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation bus endpoints:
// AXI response codes and the responder's channel state machines.
package renode_pkg;

    // AXI response codes used by the memory responder
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    // Write channel state machine
    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } write_state_t;

    // Read channel state machine
    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } read_state_t;

    // Width of the response latency counters (latency range 0..255)
    localparam int LatencyWidth = 8;

endpackage

// File: rtl/renode_word_memory.sv
// Depth x DataWidth word memory: one byte-strobed write port, one registered
// read port. Contents and the read register clear asynchronously on rst.
module renode_word_memory #(
    parameter int Depth     = 256,
    parameter int DataWidth = 32,
    parameter int IdxW      = $clog2(Depth)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IdxW-1:0]        waddr,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [DataWidth/8-1:0] wstrb,
    input  logic                   re,
    input  logic [IdxW-1:0]        raddr,
    output logic [DataWidth-1:0]   rdata
);

    // One storage array per byte lane so each strobe bit gates its own lane
    for (genvar gi = 0; gi < DataWidth / 8; gi++) begin : g_lane
        logic [7:0] lane_mem [Depth];
        logic [7:0] lane_rdata_reg;

        // Lane storage: async clear, strobed write, registered read (old data on collision)
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < Depth; i++) begin
                    lane_mem[i] <= '0;
                end
                lane_rdata_reg <= '0;
            end else begin
                if (we && wstrb[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    lane_rdata_reg <= lane_mem[raddr];
                end
            end
        end

        assign rdata[8*gi +: 8] = lane_rdata_reg;
    end

endmodule

// File: rtl/axi_lite_memory_responder.sv
// AXI4-Lite subordinate backed by a word memory. Independent write and read
// FSMs, each with its own response latency counter; out-of-range accesses
// return SLVERR and never touch memory.
module axi_lite_memory_responder
    import renode_pkg::*;
#(
    parameter int                      AddressWidth    = 32,
    parameter int                      DataWidth       = 32,
    parameter int                      Depth           = 256,
    parameter logic [AddressWidth-1:0] BaseAddress     = '0,
    parameter int                      ResponseLatency = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddressWidth-1:0] awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DataWidth-1:0]    wdata,
    input  logic [DataWidth/8-1:0]  wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [AddressWidth-1:0] araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DataWidth-1:0]    rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IdxW = $clog2(Depth);
    localparam logic [LatencyWidth-1:0] LatLoad = LatencyWidth'(ResponseLatency);
    localparam logic [AddressWidth:0]   SpanBytes = (AddressWidth+1)'(4 * Depth);

    // ---------------- address decode ----------------
    // A one-bit-wider subtraction makes addresses below the base wrap to a
    // huge offset, so a single compare covers both range bounds.
    logic [AddressWidth:0] aw_off;
    logic [AddressWidth:0] ar_off;
    logic                  aw_in_range;
    logic                  ar_in_range;

    assign aw_off      = {1'b0, awaddr} - {1'b0, BaseAddress};
    assign ar_off      = {1'b0, araddr} - {1'b0, BaseAddress};
    assign aw_in_range = aw_off < SpanBytes;
    assign ar_in_range = ar_off < SpanBytes;

    // ---------------- write path ----------------
    write_state_t              w_state_reg, w_state_next;
    logic [LatencyWidth-1:0]   w_cnt_reg, w_cnt_next;
    logic                      aw_done_reg, aw_done_next;
    logic                      w_done_reg, w_done_next;
    logic                      aw_ok_reg, aw_ok_next;
    logic [IdxW-1:0]           aw_idx_reg, aw_idx_next;
    logic [DataWidth-1:0]      wdata_reg, wdata_next;
    logic [DataWidth/8-1:0]    wstrb_reg, wstrb_next;
    axi_resp_t                 bresp_reg, bresp_next;
    logic                      awready_reg, awready_next;
    logic                      wready_reg, wready_next;
    logic                      w_commit;
    logic                      mem_we;
    logic                      aw_hs;
    logic                      w_hs;

    assign aw_hs = awvalid && awready_reg;
    assign w_hs  = wvalid && wready_reg;

    // Write state, captured request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            aw_ok_reg   <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= OKAY;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            w_cnt_reg   <= w_cnt_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            aw_ok_reg   <= aw_ok_next;
            aw_idx_reg  <= aw_idx_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            bresp_reg   <= bresp_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
        end
    end

    // Write next state: capture AW and W independently, then wait and respond
    always_comb begin
        w_state_next = w_state_reg;
        w_cnt_next   = w_cnt_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        aw_ok_next   = aw_ok_reg;
        aw_idx_next  = aw_idx_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        unique case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_next = 1'b1;
                    aw_ok_next   = aw_in_range;
                    aw_idx_next  = aw_off[IdxW+1:2];
                end
                if (w_hs) begin
                    w_done_next = 1'b1;
                    wdata_next  = wdata;
                    wstrb_next  = wstrb;
                end
                if (aw_done_reg && w_done_reg) begin
                    if (LatLoad == '0) begin
                        w_state_next = W_RESP;
                    end else begin
                        w_state_next = W_WAIT;
                        w_cnt_next   = LatLoad;
                    end
                end
            end
            W_WAIT: begin
                // Leave on the cycle the counter would reach zero
                w_cnt_next = w_cnt_reg - 1'b1;
                if (w_cnt_reg <= LatencyWidth'(1)) begin
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_next = W_IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write outputs: commit on entry to W_RESP, ready values for next cycle
    always_comb begin
        w_commit     = (w_state_next == W_RESP) && (w_state_reg != W_RESP);
        mem_we       = w_commit && aw_ok_reg;
        bresp_next   = bresp_reg;
        if (w_commit) begin
            if (aw_ok_reg) begin
                bresp_next = OKAY;
            end else begin
                bresp_next = SLVERR;
            end
        end
        awready_next = (w_state_next == W_IDLE) && !aw_done_next;
        wready_next  = (w_state_next == W_IDLE) && !w_done_next;
    end

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = (w_state_reg == W_RESP);
    assign bresp   = bresp_reg;

    // ---------------- read path ----------------
    read_state_t               r_state_reg, r_state_next;
    logic [LatencyWidth-1:0]   r_cnt_reg, r_cnt_next;
    logic                      ar_ok_reg, ar_ok_next;
    logic [IdxW-1:0]           ar_idx_reg, ar_idx_next;
    axi_resp_t                 rresp_reg, rresp_next;
    logic                      arready_reg, arready_next;
    logic                      r_sample;
    logic                      mem_re;
    logic                      ar_hs;
    logic [DataWidth-1:0]      mem_rdata;

    assign ar_hs = arvalid && arready_reg;

    // Read state, captured address and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
            ar_ok_reg   <= 1'b0;
            ar_idx_reg  <= '0;
            rresp_reg   <= OKAY;
            arready_reg <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            r_cnt_reg   <= r_cnt_next;
            ar_ok_reg   <= ar_ok_next;
            ar_idx_reg  <= ar_idx_next;
            rresp_reg   <= rresp_next;
            arready_reg <= arready_next;
        end
    end

    // Read next state: capture AR, count down the latency, hold the response
    always_comb begin
        r_state_next = r_state_reg;
        r_cnt_next   = r_cnt_reg;
        ar_ok_next   = ar_ok_reg;
        ar_idx_next  = ar_idx_reg;
        unique case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_WAIT;
                    r_cnt_next   = LatLoad;
                    ar_ok_next   = ar_in_range;
                    ar_idx_next  = ar_off[IdxW+1:2];
                end
            end
            R_WAIT: begin
                // The wait state always lasts at least one cycle because the
                // memory read port is registered.
                r_cnt_next = r_cnt_reg - 1'b1;
                if (r_cnt_reg == '0) begin
                    r_state_next = R_RESP;
                    r_cnt_next   = '0;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read outputs: sample memory on entry to R_RESP, ready value for next cycle
    always_comb begin
        r_sample     = (r_state_next == R_RESP) && (r_state_reg != R_RESP);
        mem_re       = r_sample && ar_ok_reg;
        rresp_next   = rresp_reg;
        if (r_sample) begin
            if (ar_ok_reg) begin
                rresp_next = OKAY;
            end else begin
                rresp_next = SLVERR;
            end
        end
        arready_next = (r_state_next == R_IDLE);
    end

    assign arready = arready_reg;
    assign rvalid  = (r_state_reg == R_RESP);
    assign rresp   = rresp_reg;
    // Out-of-range reads leave the memory read register untouched; mask it
    assign rdata   = (rresp_reg == SLVERR) ? '0 : mem_rdata;

    renode_word_memory #(
        .Depth     (Depth),
        .DataWidth (DataWidth),
        .IdxW      (IdxW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (aw_idx_reg),
        .wdata (wdata_reg),
        .wstrb (wstrb_reg),
        .re    (mem_re),
        .raddr (ar_idx_reg),
        .rdata (mem_rdata)
    );

endmodule
